// File: rtl/vn_collector.sv
// Result collector behind the FP32 adder switch: queues 0-2 VN results per cycle in order
// and drains one per cycle over valid/ready. Losses are flagged because the switch cannot stall.
module vn_collector #(
    parameter int DATA_TYPE = 32,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int SEQ_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*DATA_TYPE-1:0] i_vn,
    input  logic [1:0]             i_vn_valid,
    input  logic                   i_clr,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [DATA_TYPE-1:0]   o_data,
    output logic                   o_side,
    output logic [SEQ_W-1:0]       o_seq,
    output logic [ADDR_W:0]        o_count,
    output logic                   o_full,
    output logic                   o_overflow,
    output logic [15:0]            o_drop_cnt
);

    typedef struct packed {
        logic [DATA_TYPE-1:0] data;
        logic                 side;
        logic [SEQ_W-1:0]     seq;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [SEQ_W-1:0]  seq_cnt;
    logic              overflow;
    logic [15:0]       drop_cnt;

    logic              pop;
    logic [ADDR_W+1:0] room;
    logic              has0, has1, acc0, acc1;
    logic [1:0]        n_acc, n_drop;
    logic [ADDR_W-1:0] wr_ptr_p1;
    entry_t            wr0, wr1, head;
    logic [16:0]       drop_sum;
    logic [15:0]       drop_next;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        pop       = (count != '0) & i_ready;
        room      = (ADDR_W+2)'(DEPTH) - {1'b0, count} + (ADDR_W+2)'(pop);
        has0      = |i_vn_valid;
        has1      = &i_vn_valid;
        // The first offered entry needs one free slot, the second (right of a pair) needs two.
        acc0      = has0 && (room != '0);
        acc1      = has1 && (room[ADDR_W+1:1] != '0);
        n_acc     = {1'b0, acc0} + {1'b0, acc1};
        n_drop    = ({1'b0, has0} + {1'b0, has1}) - n_acc;
        wr_ptr_p1 = wr_ptr + 1'b1;

        wr0.data  = i_vn_valid[1] ? i_vn[2*DATA_TYPE-1:DATA_TYPE] : i_vn[DATA_TYPE-1:0];
        wr0.side  = i_vn_valid[1];
        wr0.seq   = seq_cnt;
        wr1.data  = i_vn[DATA_TYPE-1:0];
        wr1.side  = 1'b0;
        wr1.seq   = seq_cnt + 1'b1;

        drop_sum  = {1'b0, drop_cnt} + 17'(n_drop);
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            seq_cnt  <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wr_ptr  <= wr_ptr + ADDR_W'(n_acc);
            rd_ptr  <= rd_ptr + ADDR_W'(pop);
            count   <= count + (ADDR_W+1)'(n_acc) - (ADDR_W+1)'(pop);
            seq_cnt <= seq_cnt + SEQ_W'(n_acc);
            if (n_drop != '0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_next;
            end
        end
    end

    // NOTE: storage has no reset; empty slots are masked at the output instead.
    always_ff @(posedge clk) begin
        if (rst && !i_clr) begin
            if (acc0) mem[wr_ptr]    <= wr0;
            if (acc1) mem[wr_ptr_p1] <= wr1;
        end
    end

    always_comb begin
        head       = mem[rd_ptr];
        o_valid    = (count != '0);
        o_data     = o_valid ? head.data : '0;
        o_side     = o_valid ? head.side : 1'b0;
        o_seq      = o_valid ? head.seq  : '0;
        o_count    = count;
        o_full     = (count == (ADDR_W+1)'(DEPTH));
        o_overflow = overflow;
        o_drop_cnt = drop_cnt;
    end

endmodule

// File: tb/tb_vn_collector.sv
// Directed bench for vn_collector at DEPTH=4: ordering, tags, overflow split, full-with-pop,
// pointer wrap and clear priority, each against hand-computed values.
module tb_vn_collector;

    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int AW = 2;
    localparam int SW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*DW-1:0] i_vn;
    logic [1:0]      i_vn_valid;
    logic            i_clr;
    logic            i_ready;
    logic            o_valid;
    logic [DW-1:0]   o_data;
    logic            o_side;
    logic [SW-1:0]   o_seq;
    logic [AW:0]     o_count;
    logic            o_full;
    logic            o_overflow;
    logic [15:0]     o_drop_cnt;

    int checks = 0;
    int failures = 0;

    vn_collector #(.DATA_TYPE(DW), .DEPTH(DEPTH), .ADDR_W(AW), .SEQ_W(SW)) dut (
        .clk(clk), .rst(rst), .i_vn(i_vn), .i_vn_valid(i_vn_valid), .i_clr(i_clr),
        .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data), .o_side(o_side),
        .o_seq(o_seq), .o_count(o_count), .o_full(o_full), .o_overflow(o_overflow),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; i_clr = 1'b0; i_ready = 1'b0; i_vn_valid = 2'b00; i_vn = '0;
        step();
        rst = 1'b1;
    endtask

    task automatic push(input logic [1:0] v, input logic [DW-1:0] l, input logic [DW-1:0] r);
        i_vn_valid = v; i_vn = {l, r};
        step();
        i_vn_valid = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_clr = 1'b0; i_ready = 1'b1;
        i_vn = {32'hDEADBEEF, 32'hCAFEF00D}; i_vn_valid = 2'b11;
        step(); step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", o_valid); end
        checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", o_count); end
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%0b exp=0", o_overflow); end
        checks++; if (o_drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", o_drop_cnt); end
        checks++; if (o_data !== 32'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", o_data); end
        checks++; if ({o_side, o_seq, o_full} !== 10'd0) begin failures++; $display("FAIL rst_side_seq_full got=%b exp=0", {o_side, o_seq, o_full}); end
        rst = 1'b1; i_vn_valid = 2'b00; i_ready = 1'b0;
    endtask

    task automatic test_ordering();
        do_reset();
        push(2'b11, 32'h3F800000, 32'h40000000);
        checks++; if ({o_valid, o_count} !== {1'b1, 3'd2}) begin failures++; $display("FAIL ord_first got=%b/%0d exp=1/2", o_valid, o_count); end
        push(2'b01, 32'h0, 32'h40400000);
        checks++; if (o_count !== 3'd3) begin failures++; $display("FAIL ord_count3 got=%0d exp=3", o_count); end
        checks++; if ({o_data, o_side, o_seq} !== {32'h3F800000, 1'b1, 8'd0}) begin failures++; $display("FAIL ord_head0 got=%h/%0b/%0d exp=3f800000/1/0", o_data, o_side, o_seq); end
        i_ready = 1'b1;
        step();
        checks++; if ({o_data, o_side, o_seq, o_count} !== {32'h40000000, 1'b0, 8'd1, 3'd2}) begin failures++; $display("FAIL ord_head1 got=%h/%0b/%0d/%0d exp=40000000/0/1/2", o_data, o_side, o_seq, o_count); end
        step();
        checks++; if ({o_data, o_side, o_seq, o_count} !== {32'h40400000, 1'b0, 8'd2, 3'd1}) begin failures++; $display("FAIL ord_head2 got=%h/%0b/%0d/%0d exp=40400000/0/2/1", o_data, o_side, o_seq, o_count); end
        step();
        checks++; if ({o_valid, o_count, o_data} !== {1'b0, 3'd0, 32'd0}) begin failures++; $display("FAIL ord_empty got=%0b/%0d/%h exp=0/0/0", o_valid, o_count, o_data); end
        i_ready = 1'b0;
    endtask

    task automatic test_overflow_split();
        do_reset();
        push(2'b01, 32'h0, 32'h11);
        push(2'b01, 32'h0, 32'h22);
        push(2'b01, 32'h0, 32'h33);
        push(2'b11, 32'hAAAA0001, 32'hBBBB0002);
        checks++; if ({o_count, o_full} !== {3'd4, 1'b1}) begin failures++; $display("FAIL split_full got=%0d/%0b exp=4/1", o_count, o_full); end
        checks++; if ({o_overflow, o_drop_cnt} !== {1'b1, 16'd1}) begin failures++; $display("FAIL split_drop1 got=%0b/%0d exp=1/1", o_overflow, o_drop_cnt); end
        push(2'b10, 32'hCCCC0003, 32'h0);
        checks++; if ({o_count, o_drop_cnt} !== {3'd4, 16'd2}) begin failures++; $display("FAIL split_drop2 got=%0d/%0d exp=4/2", o_count, o_drop_cnt); end
        i_ready = 1'b1;
        step(); step(); step();
        checks++; if ({o_data, o_side, o_seq} !== {32'hAAAA0001, 1'b1, 8'd3}) begin failures++; $display("FAIL split_kept got=%h/%0b/%0d exp=aaaa0001/1/3", o_data, o_side, o_seq); end
        step();
        checks++; if ({o_valid, o_overflow} !== 2'b01) begin failures++; $display("FAIL split_sticky got=%0b/%0b exp=0/1", o_valid, o_overflow); end
        i_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        do_reset();
        push(2'b11, 32'h100, 32'h101);
        push(2'b11, 32'h102, 32'h103);
        checks++; if ({o_full, o_overflow} !== 2'b10) begin failures++; $display("FAIL fp_full got=%0b/%0b exp=1/0", o_full, o_overflow); end
        i_ready = 1'b1;
        push(2'b01, 32'h0, 32'h104);
        checks++; if ({o_count, o_overflow, o_drop_cnt} !== {3'd4, 1'b0, 16'd0}) begin failures++; $display("FAIL fp_single got=%0d/%0b/%0d exp=4/0/0", o_count, o_overflow, o_drop_cnt); end
        checks++; if ({o_data, o_seq} !== {32'h101, 8'd1}) begin failures++; $display("FAIL fp_head1 got=%h/%0d exp=101/1", o_data, o_seq); end
        push(2'b11, 32'h105, 32'h106);
        checks++; if ({o_count, o_overflow, o_drop_cnt} !== {3'd4, 1'b1, 16'd1}) begin failures++; $display("FAIL fp_pair got=%0d/%0b/%0d exp=4/1/1", o_count, o_overflow, o_drop_cnt); end
        checks++; if ({o_data, o_seq} !== {32'h102, 8'd2}) begin failures++; $display("FAIL fp_head2 got=%h/%0d exp=102/2", o_data, o_seq); end
        step(); step();
        checks++; if ({o_data, o_side, o_seq} !== {32'h104, 1'b0, 8'd4}) begin failures++; $display("FAIL fp_head4 got=%h/%0b/%0d exp=104/0/4", o_data, o_side, o_seq); end
        step();
        checks++; if ({o_data, o_side, o_seq, o_count} !== {32'h105, 1'b1, 8'd5, 3'd1}) begin failures++; $display("FAIL fp_head5 got=%h/%0b/%0d/%0d exp=105/1/5/1", o_data, o_side, o_seq, o_count); end
        step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL fp_empty got=%0b exp=0", o_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        push(2'b10, 32'h1, 32'h0);
        push(2'b10, 32'h2, 32'h0);
        push(2'b10, 32'h3, 32'h0);
        i_ready = 1'b1;
        step(); step(); step();
        checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL wrap_drained got=%0d exp=0", o_count); end
        i_ready = 1'b0;
        push(2'b11, 32'hC0DE0003, 32'hC0DE0004);
        checks++; if ({o_data, o_side, o_seq, o_count} !== {32'hC0DE0003, 1'b1, 8'd3, 3'd2}) begin failures++; $display("FAIL wrap_slot3 got=%h/%0b/%0d/%0d exp=c0de0003/1/3/2", o_data, o_side, o_seq, o_count); end
        step();
        checks++; if ({o_data, o_seq} !== {32'hC0DE0003, 8'd3}) begin failures++; $display("FAIL wrap_hold got=%h/%0d exp=c0de0003/3", o_data, o_seq); end
        i_ready = 1'b1;
        step();
        checks++; if ({o_data, o_side, o_seq} !== {32'hC0DE0004, 1'b0, 8'd4}) begin failures++; $display("FAIL wrap_slot0 got=%h/%0b/%0d exp=c0de0004/0/4", o_data, o_side, o_seq); end
        step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%0b exp=0", o_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_clear();
        do_reset();
        push(2'b11, 32'h10, 32'h11);
        push(2'b11, 32'h12, 32'h13);
        push(2'b01, 32'h0, 32'h14);
        i_ready = 1'b1;
        step(); step();
        i_ready = 1'b0;
        checks++; if ({o_count, o_overflow, o_drop_cnt} !== {3'd2, 1'b1, 16'd1}) begin failures++; $display("FAIL clr_setup got=%0d/%0b/%0d exp=2/1/1", o_count, o_overflow, o_drop_cnt); end
        i_clr = 1'b1; i_ready = 1'b1;
        push(2'b11, 32'hEEEE0001, 32'hEEEE0002);
        i_clr = 1'b0; i_ready = 1'b0;
        checks++; if ({o_count, o_valid, o_full} !== {3'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL clr_empty got=%0d/%0b/%0b exp=0/0/0", o_count, o_valid, o_full); end
        checks++; if ({o_overflow, o_drop_cnt, o_data} !== {1'b0, 16'd0, 32'd0}) begin failures++; $display("FAIL clr_flags got=%0b/%0d/%h exp=0/0/0", o_overflow, o_drop_cnt, o_data); end
        push(2'b01, 32'h0, 32'h77);
        checks++; if ({o_data, o_side, o_seq, o_count} !== {32'h77, 1'b0, 8'd0, 3'd1}) begin failures++; $display("FAIL clr_seq0 got=%h/%0b/%0d/%0d exp=77/0/0/1", o_data, o_side, o_seq, o_count); end
    endtask

    initial begin
        rst = 1'b0; i_clr = 1'b0; i_ready = 1'b0; i_vn_valid = 2'b00; i_vn = '0;
        test_reset();
        test_ordering();
        test_overflow_split();
        test_full_pop();
        test_wrap();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
